seat_reservation_ctrl: RTL and testbench
========================================

# seat_reservation_ctrl

Parametrised seat-reservation controller for the school seating system: owns a minute-based time-of-day counter, per-seat state (free / reserved / away / banned), owner ID and deadline for NUM_SEATS seats. It accepts reserve, extend, away, return, release and ban commands through a valid/ready port, and auto-expires seats with a round-robin scanner. A daily clear frees all occupied seats when the opening day rolls over. It is the next generation of the top-level seating block and absorbs the old separate timer and memory.

## Interface
- NUM_SEATS, 32, number of seats (≥2)
- SID_W, 32, student-number width
- TIME_W, 11, minute counter / duration width
- DAY_LEN, 1080, minutes per opening day (≤ 2^TIME_W)
- AWAY_MIN, 30, maximum minutes a seat may stay in AWAY
- SEAT_W, $clog2(NUM_SEATS), derived seat-index width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe, one per minute
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid && ready
- cmd_op  in  3  0 RESERVE, 1 EXTEND, 2 AWAY, 3 RETURN, 4 RELEASE, 5 BAN, 6 UNBAN, 7 illegal
- cmd_seat  in  SEAT_W  target seat
- cmd_sid  in  SID_W  student number
- cmd_dur  in  TIME_W  minutes, used by RESERVE/EXTEND
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  3  0 OK, 1 BUSY, 2 OWNER, 3 BANNED, 4 STATE, 5 RANGE
- time_out  out  TIME_W  minutes since day start
- occupied_mask  out  NUM_SEATS  bit i = seat i RESERVED or AWAY
- expire_valid  out  1  one-cycle pulse, a seat auto-expired
- expire_seat  out  SEAT_W  seat index of that expiry

## Operation
- Seat state encoding: FREE=0, RESERVED=1, AWAY=2, BANNED=3. Per seat: state, owner[SID_W], dl[TIME_W] (deadline), away_dl[TIME_W].
- Time: on tick, time_out increments. On tick with time_out==DAY_LEN-1: time_out←0 and daily clear. Daily clear sets every RESERVED/AWAY seat to FREE. BANNED persists.
- Saturating add: sum computed in TIME_W+1 bits, clamped to DAY_LEN-1.
- RANGE is checked first: cmd_seat ≥ NUM_SEATS, or cmd_dur==0 on RESERVE/EXTEND.
- RESERVE: BANNED→BANNED status. Non-FREE→BUSY. Otherwise RESERVED, owner←sid, dl←sat(now+dur).
- EXTEND: BANNED→BANNED. FREE/AWAY→STATE. Owner mismatch→OWNER. Otherwise dl←sat(dl+dur).
- AWAY: requires RESERVED (else STATE/BANNED) and owner match (else OWNER). Then state AWAY, away_dl←min(sat(now+AWAY_MIN), dl).
- RETURN: requires AWAY and owner match. Then state RESERVED; dl unchanged.
- RELEASE: requires RESERVED or AWAY and owner match. Then FREE.
- BAN: any state→BANNED, occupant dropped; sid ignored.
- UNBAN: BANNED→FREE, else STATE.
- op 7 → STATE. A failed command changes no state.
- Scanner: pointer visits one seat per cycle, wrapping NUM_SEATS-1→0.
  - RESERVED with dl ≤ time_out → FREE.
  - AWAY with away_dl ≤ time_out → FREE.
  - Each expiry pulses expire_valid with expire_seat for one cycle.
- Command and scanner on the same seat in the same cycle: command wins and the scan of that seat is skipped; the next lap re-checks it.

## Timing
- Reset: time_out=0, all seats FREE (bans cleared), owners/deadlines 0, scan pointer 0, rsp_valid=0, rsp_status=0, expire_valid=0, expire_seat=0, occupied_mask=0, cmd_ready=1.
- cmd_ready=0 only in a cycle with tick && time_out==DAY_LEN-1. The clear has priority and no command is accepted that cycle.
- Response latency: rsp_valid/rsp_status registered, 1 cycle after acceptance. Back-to-back commands are allowed, one per cycle.
- Seat state and occupied_mask update on the clock edge ending the accept cycle. A command the next cycle sees the new state.
- Expiry latency: ≤ NUM_SEATS cycles after the deadline condition becomes true.
- Daily clear and occupied_mask update take effect on the same edge as time_out←0.
- Reset mid-operation: immediate asynchronous return to reset values. A pending response is dropped.

## Test plan
- Reserve and expire: at time_out=100, RESERVE seat 3, sid 0x1234, dur 60 → rsp OK, occupied_mask[3]=1. After 60 ticks (time 160), expire_valid with expire_seat=3 within 32 cycles; mask bit clears.
- Ownership: RESERVE seat 5 sid A.
  - EXTEND seat 5 sid B → OWNER.
  - RESERVE seat 5 sid B → BUSY.
  - RELEASE seat 5 sid A → OK, seat FREE.
- Away timeout: RESERVE seat 0, dur 200, at time 10. AWAY at time 20 → OK. No RETURN; seat expires when time_out reaches 50. RETURN afterwards → STATE.
- Daily clear: seats 1 and 2 RESERVED, seat 7 BAN. Drive tick with time_out=1079 and cmd_valid held → cmd_ready=0 that cycle. time_out→0, seats 1 and 2 FREE, seat 7 still BANNED. RESERVE seat 7 → BANNED.
- Saturation and range:
  - RESERVE at time 1000, dur 2047 → dl=1079.
  - cmd_dur=0 → RANGE.
  - op 7 → STATE.
  - With NUM_SEATS=20, seat 25 → RANGE.
- Collision and reset: issue RELEASE on a seat in the same cycle the scanner reaches it with its deadline already passed → rsp OK, no expire_valid pulse. Assert rst_n mid-burst → all outputs return to reset values immediately.

Source files
------------

// File: rtl/seat_reservation_ctrl.sv
// Seat-reservation controller: minute clock, per-seat state/owner/deadline store,
// valid/ready command port, round-robin expiry scanner and end-of-day clear.
module seat_reservation_ctrl #(
    parameter int NUM_SEATS = 32,
    parameter int SID_W     = 32,
    parameter int TIME_W    = 11,
    parameter int DAY_LEN   = 1080,
    parameter int AWAY_MIN  = 30,
    parameter int SEAT_W    = $clog2(NUM_SEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [SEAT_W-1:0]    cmd_seat,
    input  logic [SID_W-1:0]     cmd_sid,
    input  logic [TIME_W-1:0]    cmd_dur,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_status,
    output logic [TIME_W-1:0]    time_out,
    output logic [NUM_SEATS-1:0] occupied_mask,
    output logic                 expire_valid,
    output logic [SEAT_W-1:0]    expire_seat
);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_RES  = 2'd1;
    localparam logic [1:0] ST_AWAY = 2'd2;
    localparam logic [1:0] ST_BAN  = 2'd3;

    localparam logic [2:0] OP_RESERVE = 3'd0;
    localparam logic [2:0] OP_EXTEND  = 3'd1;
    localparam logic [2:0] OP_AWAY    = 3'd2;
    localparam logic [2:0] OP_RETURN  = 3'd3;
    localparam logic [2:0] OP_RELEASE = 3'd4;
    localparam logic [2:0] OP_BAN     = 3'd5;
    localparam logic [2:0] OP_UNBAN   = 3'd6;

    localparam logic [2:0] RS_OK     = 3'd0;
    localparam logic [2:0] RS_BUSY   = 3'd1;
    localparam logic [2:0] RS_OWNER  = 3'd2;
    localparam logic [2:0] RS_BANNED = 3'd3;
    localparam logic [2:0] RS_STATE  = 3'd4;
    localparam logic [2:0] RS_RANGE  = 3'd5;

    localparam logic [TIME_W-1:0] LAST_MIN  = TIME_W'(DAY_LEN - 1);
    localparam logic [TIME_W-1:0] AWAY_T    = TIME_W'(AWAY_MIN);
    localparam logic [SEAT_W:0]   SEAT_LIM  = (SEAT_W + 1)'(NUM_SEATS);
    localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_SEATS - 1);

    // Minute addition that never runs past the last minute of the day.
    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                  input logic [TIME_W-1:0] b);
        logic [TIME_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, LAST_MIN}) begin
            sat_add = LAST_MIN;
        end else begin
            sat_add = sum[TIME_W-1:0];
        end
    endfunction

    logic [1:0]           state_q   [NUM_SEATS];
    logic [1:0]           state_d   [NUM_SEATS];
    logic [SID_W-1:0]     owner_q   [NUM_SEATS];
    logic [SID_W-1:0]     owner_d   [NUM_SEATS];
    logic [TIME_W-1:0]    dl_q      [NUM_SEATS];
    logic [TIME_W-1:0]    dl_d      [NUM_SEATS];
    logic [TIME_W-1:0]    away_dl_q [NUM_SEATS];
    logic [TIME_W-1:0]    away_dl_d [NUM_SEATS];

    logic [TIME_W-1:0]    time_q, time_d;
    logic [SEAT_W-1:0]    scan_q, scan_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2:0]           rsp_status_q, rsp_status_d;
    logic                 exp_valid_q, exp_valid_d;
    logic [SEAT_W-1:0]    exp_seat_q, exp_seat_d;
    logic [NUM_SEATS-1:0] occ_q, occ_d;

    logic                 day_end_s;
    logic                 accept_s;
    logic                 seat_ok_s;
    logic                 dur_op_s;
    logic                 owner_ok_s;
    logic [1:0]           tgt_state_s;
    logic [TIME_W-1:0]    tgt_dl_s;
    logic [2:0]           status_s;
    logic [TIME_W-1:0]    res_dl_s;
    logic [TIME_W-1:0]    ext_dl_s;
    logic [TIME_W-1:0]    away_lim_s;
    logic [TIME_W-1:0]    away_dl_s;
    logic                 scan_due_s;
    logic                 scan_skip_s;

    // Minute counter; the last tick of the day wraps to zero and blocks commands.
    always_comb begin
        day_end_s = tick && (time_q == LAST_MIN);
        if (day_end_s) begin
            time_d = '0;
        end else if (tick) begin
            time_d = time_q + TIME_W'(1);
        end else begin
            time_d = time_q;
        end
        accept_s = cmd_valid && !day_end_s;
    end

    assign cmd_ready = !day_end_s;

    // Command decode: range check first, then per-op state/ownership rules.
    always_comb begin
        seat_ok_s = ({1'b0, cmd_seat} < SEAT_LIM);
        dur_op_s  = (cmd_op == OP_RESERVE) || (cmd_op == OP_EXTEND);
        if (seat_ok_s) begin
            tgt_state_s = state_q[cmd_seat];
            owner_ok_s  = (owner_q[cmd_seat] == cmd_sid);
            tgt_dl_s    = dl_q[cmd_seat];
        end else begin
            tgt_state_s = ST_FREE;
            owner_ok_s  = 1'b0;
            tgt_dl_s    = '0;
        end

        if (!seat_ok_s || (dur_op_s && (cmd_dur == '0))) begin
            status_s = RS_RANGE;
        end else begin
            case (cmd_op)
                OP_RESERVE: begin
                    if (tgt_state_s == ST_BAN)       status_s = RS_BANNED;
                    else if (tgt_state_s != ST_FREE) status_s = RS_BUSY;
                    else                             status_s = RS_OK;
                end
                OP_EXTEND, OP_AWAY: begin
                    if (tgt_state_s == ST_BAN)       status_s = RS_BANNED;
                    else if (tgt_state_s != ST_RES)  status_s = RS_STATE;
                    else if (!owner_ok_s)            status_s = RS_OWNER;
                    else                             status_s = RS_OK;
                end
                OP_RETURN: begin
                    if (tgt_state_s == ST_BAN)       status_s = RS_BANNED;
                    else if (tgt_state_s != ST_AWAY) status_s = RS_STATE;
                    else if (!owner_ok_s)            status_s = RS_OWNER;
                    else                             status_s = RS_OK;
                end
                OP_RELEASE: begin
                    if (tgt_state_s == ST_BAN)       status_s = RS_BANNED;
                    else if (tgt_state_s == ST_FREE) status_s = RS_STATE;
                    else if (!owner_ok_s)            status_s = RS_OWNER;
                    else                             status_s = RS_OK;
                end
                OP_BAN: begin
                    status_s = RS_OK;
                end
                OP_UNBAN: begin
                    if (tgt_state_s == ST_BAN)       status_s = RS_OK;
                    else                             status_s = RS_STATE;
                end
                default: begin
                    status_s = RS_STATE;
                end
            endcase
        end

        res_dl_s   = sat_add(time_q, cmd_dur);
        ext_dl_s   = sat_add(tgt_dl_s, cmd_dur);
        away_lim_s = sat_add(time_q, AWAY_T);
        if (away_lim_s < tgt_dl_s) begin
            away_dl_s = away_lim_s;
        end else begin
            away_dl_s = tgt_dl_s;
        end
    end

    // Scanner check for the seat under the pointer; an accepted command on it wins.
    always_comb begin
        case (state_q[scan_q])
            ST_RES:  scan_due_s = (dl_q[scan_q] <= time_q);
            ST_AWAY: scan_due_s = (away_dl_q[scan_q] <= time_q);
            default: scan_due_s = 1'b0;
        endcase
        scan_skip_s = day_end_s || (accept_s && seat_ok_s && (cmd_seat == scan_q));
        if (scan_q == LAST_SEAT) begin
            scan_d = '0;
        end else begin
            scan_d = scan_q + SEAT_W'(1);
        end
    end

    // Next seat table: expiry, then the accepted command, then the daily clear.
    always_comb begin
        for (int i = 0; i < NUM_SEATS; i++) begin
            state_d[i]   = state_q[i];
            owner_d[i]   = owner_q[i];
            dl_d[i]      = dl_q[i];
            away_dl_d[i] = away_dl_q[i];
        end

        if (scan_due_s && !scan_skip_s) begin
            state_d[scan_q] = ST_FREE;
            exp_valid_d     = 1'b1;
            exp_seat_d      = scan_q;
        end else begin
            exp_valid_d     = 1'b0;
            exp_seat_d      = exp_seat_q;
        end

        if (accept_s && (status_s == RS_OK)) begin
            case (cmd_op)
                OP_RESERVE: begin
                    state_d[cmd_seat] = ST_RES;
                    owner_d[cmd_seat] = cmd_sid;
                    dl_d[cmd_seat]    = res_dl_s;
                end
                OP_EXTEND: begin
                    dl_d[cmd_seat] = ext_dl_s;
                end
                OP_AWAY: begin
                    state_d[cmd_seat]   = ST_AWAY;
                    away_dl_d[cmd_seat] = away_dl_s;
                end
                OP_RETURN: begin
                    state_d[cmd_seat] = ST_RES;
                end
                OP_RELEASE, OP_UNBAN: begin
                    state_d[cmd_seat] = ST_FREE;
                end
                OP_BAN: begin
                    state_d[cmd_seat]   = ST_BAN;
                    owner_d[cmd_seat]   = '0;
                    dl_d[cmd_seat]      = '0;
                    away_dl_d[cmd_seat] = '0;
                end
                default: begin
                    state_d[cmd_seat] = state_q[cmd_seat];
                end
            endcase
        end else begin
            rsp_status_d = rsp_status_q;
        end

        if (day_end_s) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                if ((state_q[i] == ST_RES) || (state_q[i] == ST_AWAY)) begin
                    state_d[i] = ST_FREE;
                end else begin
                    state_d[i] = state_q[i];
                end
            end
        end else begin
            occ_d = '0;
        end

        for (int i = 0; i < NUM_SEATS; i++) begin
            occ_d[i] = (state_d[i] == ST_RES) || (state_d[i] == ST_AWAY);
        end

        rsp_valid_d = accept_s;
        if (accept_s) begin
            rsp_status_d = status_s;
        end else begin
            rsp_status_d = rsp_status_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                state_q[i]   <= ST_FREE;
                owner_q[i]   <= '0;
                dl_q[i]      <= '0;
                away_dl_q[i] <= '0;
            end
            time_q       <= '0;
            scan_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 3'd0;
            exp_valid_q  <= 1'b0;
            exp_seat_q   <= '0;
            occ_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                state_q[i]   <= state_d[i];
                owner_q[i]   <= owner_d[i];
                dl_q[i]      <= dl_d[i];
                away_dl_q[i] <= away_dl_d[i];
            end
            time_q       <= time_d;
            scan_q       <= scan_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            exp_valid_q  <= exp_valid_d;
            exp_seat_q   <= exp_seat_d;
            occ_q        <= occ_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = rsp_status_q;
    assign time_out      = time_q;
    assign occupied_mask = occ_q;
    assign expire_valid  = exp_valid_q;
    assign expire_seat   = exp_seat_q;

endmodule

// File: tb/tb_seat_reservation_ctrl.sv
// Self-checking bench for seat_reservation_ctrl: directed scenarios plus a
// randomized run against a seat-table reference model.
module tb_seat_reservation_ctrl;

    localparam int N        = 20;
    localparam int SEAT_W   = 5;
    localparam int TIME_W   = 11;
    localparam int DAY_LEN  = 1080;
    localparam int AWAY_MIN = 30;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [SEAT_W-1:0] cmd_seat = '0;
    logic [31:0]       cmd_sid = 32'd0;
    logic [TIME_W-1:0] cmd_dur = '0;
    logic              rsp_valid;
    logic [2:0]        rsp_status;
    logic [TIME_W-1:0] time_out;
    logic [N-1:0]      occupied_mask;
    logic              expire_valid;
    logic [SEAT_W-1:0] expire_seat;

    seat_reservation_ctrl #(
        .NUM_SEATS(N), .SID_W(32), .TIME_W(TIME_W), .DAY_LEN(DAY_LEN), .AWAY_MIN(AWAY_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_seat(cmd_seat), .cmd_sid(cmd_sid), .cmd_dur(cmd_dur),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .time_out(time_out),
        .occupied_mask(occupied_mask), .expire_valid(expire_valid), .expire_seat(expire_seat)
    );

    always #5 clk = ~clk;

    // Reference model: 0 free, 1 reserved, 2 away, 3 banned.
    int          m_state [N];
    logic [31:0] m_owner [N];
    int          m_dl    [N];
    int          m_adl   [N];
    int          m_time;
    int          m_ptr;
    bit          e_ready, e_rsp_v, e_exp_v, o_ready;
    int          e_rsp_st, e_exp_seat;
    logic [N-1:0] e_mask;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int m_status(int op, int seat, logic [31:0] sid, int dur);
        int st;
        bit own;
        if (seat >= N) return 5;
        if ((op == 0 || op == 1) && dur == 0) return 5;
        st  = m_state[seat];
        own = (m_owner[seat] == sid);
        case (op)
            0: return (st == 3) ? 3 : (st != 0) ? 1 : 0;
            1, 2: return (st == 3) ? 3 : (st != 1) ? 4 : !own ? 2 : 0;
            3: return (st == 3) ? 3 : (st != 2) ? 4 : !own ? 2 : 0;
            4: return (st == 3) ? 3 : (st == 0) ? 4 : !own ? 2 : 0;
            5: return 0;
            6: return (st == 3) ? 0 : 4;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_owner[i] = 32'd0; m_dl[i] = 0; m_adl[i] = 0;
        end
        m_time = 0; m_ptr = 0; e_rsp_v = 1'b0; e_exp_v = 1'b0; e_mask = '0;
        e_rsp_st = 0; e_exp_seat = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, then sample just after the edge.
    task automatic cyc(input bit t, input bit v, input int op, input int seat,
                       input logic [31:0] sid, input int dur);
        int st, s;
        bit de, acc, skip, ex;
        tick = t; cmd_valid = v; cmd_op = 3'(op); cmd_seat = SEAT_W'(seat);
        cmd_sid = sid; cmd_dur = TIME_W'(dur);
        de = t && (m_time == DAY_LEN - 1);
        e_ready = !de;
        acc = v && !de;
        st = acc ? m_status(op, seat, sid, dur) : 0;
        s = m_ptr;
        skip = acc && (seat == s);
        ex = !de && !skip && ((m_state[s] == 1 && m_dl[s] <= m_time) ||
                              (m_state[s] == 2 && m_adl[s] <= m_time));
        e_exp_v = ex;
        if (ex) begin
            e_exp_seat = s;
            m_state[s] = 0;
        end
        e_rsp_v = acc;
        if (acc) e_rsp_st = st;
        if (acc && st == 0) begin
            case (op)
                0: begin m_state[seat] = 1; m_owner[seat] = sid;
                         m_dl[seat] = min2(m_time + dur, DAY_LEN - 1); end
                1: m_dl[seat] = min2(m_dl[seat] + dur, DAY_LEN - 1);
                2: begin m_state[seat] = 2;
                         m_adl[seat] = min2(min2(m_time + AWAY_MIN, DAY_LEN - 1), m_dl[seat]); end
                3: m_state[seat] = 1;
                4, 6: m_state[seat] = 0;
                5: m_state[seat] = 3;
                default: ;
            endcase
        end
        if (de) begin
            for (int i = 0; i < N; i++) if (m_state[i] == 1 || m_state[i] == 2) m_state[i] = 0;
        end
        if (t) m_time = de ? 0 : m_time + 1;
        m_ptr = (m_ptr + 1) % N;
        for (int i = 0; i < N; i++) e_mask[i] = (m_state[i] == 1 || m_state[i] == 2);
        #1 o_ready = cmd_ready;
        @(posedge clk); #1;
    endtask

    task automatic tick_to(input int target);
        while (m_time != target) cyc(1'b1, 1'b0, 0, 0, 32'd0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_status got %0d want 0", rsp_status); end
        n_cmp++; if (expire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_expire_valid got %b want 0", expire_valid); end
        n_cmp++; if (expire_seat !== 5'd0) begin n_fail++; $display("FAIL reset_expire_seat got %0d want 0", expire_seat); end
        n_cmp++; if (occupied_mask !== 20'd0) begin n_fail++; $display("FAIL reset_mask got %h want 0", occupied_mask); end
        n_cmp++; if (time_out !== 11'd0) begin n_fail++; $display("FAIL reset_time got %0d want 0", time_out); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        do_reset();
    endtask

    task automatic test_reserve_expire();
        bit found;
        tick_to(100);
        n_cmp++; if (time_out !== 11'd100) begin n_fail++; $display("FAIL re_time got %0d want 100", time_out); end
        cyc(1'b0, 1'b1, 0, 3, 32'h1234, 60);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_status !== 3'd0) begin n_fail++; $display("FAIL re_rsp got v%b s%0d want v1 s0", rsp_valid, rsp_status); end
        n_cmp++; if (occupied_mask[3] !== 1'b1) begin n_fail++; $display("FAIL re_mask_set got %b want 1", occupied_mask[3]); end
        for (int k = 0; k < 60; k++) begin
            cyc(1'b1, 1'b0, 0, 0, 32'd0, 0);
            n_cmp++; if (expire_valid !== 1'b0) begin n_fail++; $display("FAIL re_early_expire got %b want 0 at k=%0d", expire_valid, k); end
        end
        n_cmp++; if (time_out !== 11'd160) begin n_fail++; $display("FAIL re_time160 got %0d want 160", time_out); end
        found = 1'b0;
        for (int k = 0; k < N && !found; k++) begin
            cyc(1'b0, 1'b0, 0, 0, 32'd0, 0);
            if (expire_valid === 1'b1) begin
                found = 1'b1;
                n_cmp++; if (expire_seat !== 5'd3) begin n_fail++; $display("FAIL re_exp_seat got %0d want 3", expire_seat); end
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL re_expire_timeout got none want seat 3"); end
        n_cmp++; if (occupied_mask[3] !== 1'b0) begin n_fail++; $display("FAIL re_mask_clear got %b want 0", occupied_mask[3]); end
    endtask

    task automatic test_ownership();
        cyc(1'b0, 1'b1, 0, 5, 32'hA, 100);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL own_reserve got %0d want 0", rsp_status); end
        cyc(1'b0, 1'b1, 1, 5, 32'hB, 10);
        n_cmp++; if (rsp_status !== 3'd2) begin n_fail++; $display("FAIL own_extend got %0d want 2", rsp_status); end
        cyc(1'b0, 1'b1, 0, 5, 32'hB, 10);
        n_cmp++; if (rsp_status !== 3'd1) begin n_fail++; $display("FAIL own_busy got %0d want 1", rsp_status); end
        cyc(1'b0, 1'b1, 4, 5, 32'hA, 0);
        n_cmp++; if (rsp_status !== 3'd0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL own_release got v%b s%0d want v1 s0", rsp_valid, rsp_status); end
        n_cmp++; if (occupied_mask[5] !== 1'b0) begin n_fail++; $display("FAIL own_mask got %b want 0", occupied_mask[5]); end
    endtask

    task automatic test_away_timeout();
        bit found;
        do_reset();
        tick_to(10);
        cyc(1'b0, 1'b1, 0, 0, 32'h77, 200);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL away_reserve got %0d want 0", rsp_status); end
        tick_to(20);
        cyc(1'b0, 1'b1, 2, 0, 32'h77, 0);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL away_cmd got %0d want 0", rsp_status); end
        tick_to(50);
        n_cmp++; if (occupied_mask[0] !== 1'b1) begin n_fail++; $display("FAIL away_early got %b want 1", occupied_mask[0]); end
        found = 1'b0;
        for (int k = 0; k < N && !found; k++) begin
            cyc(1'b0, 1'b0, 0, 0, 32'd0, 0);
            if (expire_valid === 1'b1) begin
                found = 1'b1;
                n_cmp++; if (expire_seat !== 5'd0) begin n_fail++; $display("FAIL away_exp_seat got %0d want 0", expire_seat); end
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL away_expire_timeout got none want seat 0"); end
        cyc(1'b0, 1'b1, 3, 0, 32'h77, 0);
        n_cmp++; if (rsp_status !== 3'd4) begin n_fail++; $display("FAIL away_return got %0d want 4", rsp_status); end
    endtask

    task automatic test_daily_clear();
        do_reset();
        cyc(1'b0, 1'b1, 0, 1, 32'h11, 2000);
        cyc(1'b0, 1'b1, 0, 2, 32'h22, 2000);
        cyc(1'b0, 1'b1, 5, 7, 32'h0, 0);
        tick_to(DAY_LEN - 1);
        n_cmp++; if (occupied_mask[2:1] !== 2'b11) begin n_fail++; $display("FAIL dc_before got %b want 11", occupied_mask[2:1]); end
        cyc(1'b1, 1'b1, 0, 9, 32'h99, 50);
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL dc_ready got %b want 0", o_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dc_no_rsp got %b want 0", rsp_valid); end
        n_cmp++; if (time_out !== 11'd0) begin n_fail++; $display("FAIL dc_time got %0d want 0", time_out); end
        n_cmp++; if (occupied_mask !== 20'd0) begin n_fail++; $display("FAIL dc_mask got %h want 0", occupied_mask); end
        cyc(1'b0, 1'b1, 0, 7, 32'h33, 50);
        n_cmp++; if (rsp_status !== 3'd3) begin n_fail++; $display("FAIL dc_banned got %0d want 3", rsp_status); end
        cyc(1'b0, 1'b1, 6, 7, 32'h0, 0);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL dc_unban got %0d want 0", rsp_status); end
    endtask

    task automatic test_saturation_range();
        bit found;
        tick_to(1000);
        cyc(1'b0, 1'b1, 0, 4, 32'h44, 2047);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL sat_reserve got %0d want 0", rsp_status); end
        while (m_time != DAY_LEN - 1) begin
            cyc(1'b1, 1'b0, 0, 0, 32'd0, 0);
            n_cmp++; if (expire_valid === 1'b1 && expire_seat === 5'd4) begin n_fail++; $display("FAIL sat_early_expire got seat 4 at %0d want none", time_out); end
        end
        n_cmp++; if (occupied_mask[4] !== 1'b1) begin n_fail++; $display("FAIL sat_held got %b want 1", occupied_mask[4]); end
        found = 1'b0;
        for (int k = 0; k < N && !found; k++) begin
            cyc(1'b0, 1'b0, 0, 0, 32'd0, 0);
            if (expire_valid === 1'b1 && expire_seat === 5'd4) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL sat_expire_1079 got none want seat 4"); end
        cyc(1'b0, 1'b1, 0, 6, 32'h1, 0);
        n_cmp++; if (rsp_status !== 3'd5) begin n_fail++; $display("FAIL rng_dur0 got %0d want 5", rsp_status); end
        cyc(1'b0, 1'b1, 1, 6, 32'h1, 0);
        n_cmp++; if (rsp_status !== 3'd5) begin n_fail++; $display("FAIL rng_ext_dur0 got %0d want 5", rsp_status); end
        cyc(1'b0, 1'b1, 7, 6, 32'h1, 5);
        n_cmp++; if (rsp_status !== 3'd4) begin n_fail++; $display("FAIL op7 got %0d want 4", rsp_status); end
        cyc(1'b0, 1'b1, 0, 25, 32'h1, 5);
        n_cmp++; if (rsp_status !== 3'd5) begin n_fail++; $display("FAIL rng_seat25 got %0d want 5", rsp_status); end
        cyc(1'b0, 1'b1, 5, 20, 32'h1, 5);
        n_cmp++; if (rsp_status !== 3'd5) begin n_fail++; $display("FAIL rng_seat20 got %0d want 5", rsp_status); end
        cyc(1'b0, 1'b1, 0, 19, 32'h1, 5);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL rng_seat19 got %0d want 0", rsp_status); end
    endtask

    task automatic test_collision();
        int tgt, guard;
        do_reset();
        tgt = (m_ptr + 10) % N;
        cyc(1'b1, 1'b1, 0, tgt, 32'h55, 1);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL col_reserve got %0d want 0", rsp_status); end
        guard = 0;
        while (m_ptr != tgt && guard < 2 * N) begin
            cyc(1'b0, 1'b0, 0, 0, 32'd0, 0);
            guard++;
        end
        cyc(1'b0, 1'b1, 4, tgt, 32'h55, 0);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_status !== 3'd0) begin n_fail++; $display("FAIL col_release got v%b s%0d want v1 s0", rsp_valid, rsp_status); end
        n_cmp++; if (expire_valid !== 1'b0) begin n_fail++; $display("FAIL col_no_expire got %b want 0", expire_valid); end
        n_cmp++; if (occupied_mask[tgt] !== 1'b0) begin n_fail++; $display("FAIL col_mask got %b want 0", occupied_mask[tgt]); end
    endtask

    task automatic test_random();
        int op, seat, dur;
        bit t, v;
        logic [31:0] sid;
        for (int k = 0; k < 2500; k++) begin
            t    = 1'($urandom_range(0, 1));
            v    = ($urandom_range(0, 9) < 7);
            op   = $urandom_range(0, 7);
            seat = $urandom_range(0, 21);
            sid  = 32'h100 + 32'($urandom_range(0, 2));
            dur  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
            cyc(t, v, op, seat, sid, dur);
            n_cmp++; if (o_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready got %b want %b", o_ready, e_ready); end
            n_cmp++; if (rsp_valid !== e_rsp_v) begin n_fail++; $display("FAIL rnd_rsp_valid got %b want %b", rsp_valid, e_rsp_v); end
            if (e_rsp_v) begin
                n_cmp++; if (rsp_status !== 3'(e_rsp_st)) begin n_fail++; $display("FAIL rnd_status got %0d want %0d op %0d seat %0d", rsp_status, e_rsp_st, op, seat); end
            end
            n_cmp++; if (expire_valid !== e_exp_v) begin n_fail++; $display("FAIL rnd_expire_valid got %b want %b", expire_valid, e_exp_v); end
            if (e_exp_v) begin
                n_cmp++; if (expire_seat !== 5'(e_exp_seat)) begin n_fail++; $display("FAIL rnd_expire_seat got %0d want %0d", expire_seat, e_exp_seat); end
            end
            n_cmp++; if (time_out !== 11'(m_time)) begin n_fail++; $display("FAIL rnd_time got %0d want %0d", time_out, m_time); end
            n_cmp++; if (occupied_mask !== e_mask) begin n_fail++; $display("FAIL rnd_mask got %h want %h", occupied_mask, e_mask); end
        end
        // Reset lands while a response is pending from the previous command.
        cyc(1'b1, 1'b1, 5, 8, 32'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rsp got %b want 0", rsp_valid); end
        n_cmp++; if (time_out !== 11'd0) begin n_fail++; $display("FAIL mid_rst_time got %0d want 0", time_out); end
        n_cmp++; if (occupied_mask !== 20'd0) begin n_fail++; $display("FAIL mid_rst_mask got %h want 0", occupied_mask); end
        n_cmp++; if (expire_valid !== 1'b0 || expire_seat !== 5'd0) begin n_fail++; $display("FAIL mid_rst_expire got v%b s%0d want v0 s0", expire_valid, expire_seat); end
        n_cmp++; if (rsp_status !== 3'd0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_status got s%0d r%b want s0 r1", rsp_status, cmd_ready); end
        do_reset();
        cyc(1'b0, 1'b1, 0, 8, 32'h1, 5);
        n_cmp++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL post_rst_unbanned got %0d want 0", rsp_status); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reserve_expire();
        test_ownership();
        test_away_timeout();
        test_daily_clear();
        test_saturation_range();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
